// File: rtl/block_field_ctrl_pkg.sv
// Shared encodings for the block field controller: block types and FSM states.
package block_field_ctrl_pkg;

    // Type 0 is a solid landing cell; every nonzero type is a hazard.
    localparam int BT_SOLID = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_LAND   = 2'd2,
        ST_FAIL   = 2'd3
    } state_e;

endpackage

// File: rtl/block_field_ctrl_field_row.sv
// One field row: LANES block-present bits plus TYPE_W type bits per lane.
module block_field_ctrl_field_row #(
    parameter int               LANES   = 7,
    parameter int               TYPE_W  = 1,
    parameter logic [LANES-1:0] RST_MAP = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [LANES-1:0]        map_i,
    input  logic [LANES*TYPE_W-1:0] type_i,
    output logic [LANES-1:0]        map_o,
    output logic [LANES*TYPE_W-1:0] type_o
);

    logic [LANES-1:0]        map_q;
    logic [LANES*TYPE_W-1:0] type_q;

    // Row storage: seeded on reset, reloaded from the row above when the field scrolls.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q  <= RST_MAP;
            type_q <= '0;
        end else if (load_i) begin
            map_q  <= map_i;
            type_q <= type_i;
        end
    end

    assign map_o  = map_q;
    assign type_o = type_q;

endmodule

// File: rtl/block_field_ctrl.sv
// Game-field controller: row grid, character column and the scroll-then-land jump sequence.
module block_field_ctrl
    import block_field_ctrl_pkg::*;
#(
    parameter int  LANES     = 7,
    parameter int  ROWS      = 5,
    parameter int  CHAR_ROW  = 3,
    parameter int  START_COL = 3,
    parameter int  TYPE_W    = 1,
    parameter int  SCROLL_MS = 200,
    parameter int  SCORE_W   = 10,
    localparam int CW        = $clog2(LANES),
    localparam int SW        = $clog2(SCROLL_MS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          one_ms_tick,
    input  logic                          jump_left,
    input  logic                          jump_right,
    input  logic [LANES-1:0]              gen_map,
    input  logic [LANES*TYPE_W-1:0]       gen_type,
    output logic                          gen_req,
    output logic [ROWS*LANES-1:0]         row_map,
    output logic [ROWS*LANES*TYPE_W-1:0]  row_type,
    output logic [CW-1:0]                 char_col,
    output logic [SW-1:0]                 scroll_cnt,
    output logic                          busy,
    output logic                          jump_fail,
    output logic [SCORE_W-1:0]            score
);

    state_e                  state_q;
    logic [CW-1:0]           col_q, tgt_q;
    logic [SW-1:0]           cnt_q;
    logic [SCORE_W-1:0]      score_q;
    logic                    fail_q;
    logic [LANES-1:0]        pend_map_q;
    logic [LANES*TYPE_W-1:0] pend_type_q;

    logic [ROWS-1:0][LANES-1:0]        map_w;
    logic [ROWS-1:0][LANES*TYPE_W-1:0] type_w;
    logic [LANES-1:0]                  src_map  [ROWS];
    logic [LANES*TYPE_W-1:0]           src_type [ROWS];

    logic              want_jump, at_edge, shift, land_ok;
    logic [TYPE_W-1:0] land_type;

    // A jump is only a request when exactly one direction is asserted while idle and enabled.
    assign want_jump = (state_q == ST_IDLE) && enable && (jump_left ^ jump_right);
    assign at_edge   = (jump_left && (col_q == '0)) || (jump_right && (col_q == CW'(LANES - 1)));
    assign gen_req   = want_jump && !at_edge;
    // The scroll completes on the tick that would bring the count to SCROLL_MS.
    assign shift     = (state_q == ST_SCROLL) && one_ms_tick && (cnt_q == SW'(SCROLL_MS - 1));

    // In LAND the grid has already shifted, so this looks at the row the character landed on.
    assign land_type = type_w[CHAR_ROW][col_q*TYPE_W +: TYPE_W];
    assign land_ok   = map_w[CHAR_ROW][col_q] && (land_type == TYPE_W'(BT_SOLID));

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [LANES-1:0] SEED = (r == CHAR_ROW) ? (LANES'(1) << START_COL) : '0;

        if (r == 0) begin : g_src
            assign src_map[r]  = pend_map_q;
            assign src_type[r] = pend_type_q;
        end else begin : g_src
            assign src_map[r]  = map_w[r-1];
            assign src_type[r] = type_w[r-1];
        end

        block_field_ctrl_field_row #(
            .LANES   (LANES),
            .TYPE_W  (TYPE_W),
            .RST_MAP (SEED)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .load_i (shift),
            .map_i  (src_map[r]),
            .type_i (src_type[r]),
            .map_o  (map_w[r]),
            .type_o (type_w[r])
        );
    end

    // Jump sequencer: target latch, scroll count, landing check and score; FAIL holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= CW'(START_COL);
            tgt_q       <= CW'(START_COL);
            cnt_q       <= '0;
            score_q     <= '0;
            fail_q      <= 1'b0;
            pend_map_q  <= '0;
            pend_type_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (want_jump) begin
                        if (at_edge) begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            tgt_q       <= jump_right ? col_q + 1'b1 : col_q - 1'b1;
                            pend_map_q  <= gen_map;
                            pend_type_q <= gen_type;
                            cnt_q       <= '0;
                            state_q     <= ST_SCROLL;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (one_ms_tick) begin
                        if (shift) begin
                            cnt_q   <= '0;
                            col_q   <= tgt_q;
                            state_q <= ST_LAND;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_LAND: begin
                    if (land_ok) begin
                        if (score_q != '1) score_q <= score_q + 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                    end
                end
                default: ;  // ST_FAIL: everything frozen
            endcase
        end
    end

    assign row_map    = map_w;
    assign row_type   = type_w;
    assign char_col   = col_q;
    assign scroll_cnt = cnt_q;
    assign busy       = (state_q != ST_IDLE);
    assign jump_fail  = fail_q;
    assign score      = score_q;

endmodule

// File: tb/tb_block_field_ctrl.sv
// Directed bench: DUT A uses default parameters; DUT B lands on row 0 with a short scroll and 2-bit score.
module tb_block_field_ctrl;

    logic       clk = 1'b0;
    logic       rst, en_a, en_b, tick, jl, jr;
    logic [6:0] gmap, gtype;

    logic        gen_req_a, busy_a, fail_a;
    logic [34:0] row_map_a, row_type_a;
    logic [2:0]  char_col_a;
    logic [7:0]  scroll_cnt_a;
    logic [9:0]  score_a;

    logic        gen_req_b, busy_b, fail_b;
    logic [34:0] row_map_b, row_type_b;
    logic [2:0]  char_col_b;
    logic [1:0]  scroll_cnt_b;
    logic [1:0]  score_b;

    block_field_ctrl dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .one_ms_tick(tick),
        .jump_left(jl), .jump_right(jr), .gen_map(gmap), .gen_type(gtype),
        .gen_req(gen_req_a), .row_map(row_map_a), .row_type(row_type_a),
        .char_col(char_col_a), .scroll_cnt(scroll_cnt_a), .busy(busy_a),
        .jump_fail(fail_a), .score(score_a)
    );

    block_field_ctrl #(
        .LANES(7), .ROWS(5), .CHAR_ROW(0), .START_COL(3), .TYPE_W(1),
        .SCROLL_MS(3), .SCORE_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .one_ms_tick(tick),
        .jump_left(jl), .jump_right(jr), .gen_map(gmap), .gen_type(gtype),
        .gen_req(gen_req_b), .row_map(row_map_b), .row_type(row_type_b),
        .char_col(char_col_b), .scroll_cnt(scroll_cnt_b), .busy(busy_b),
        .jump_fail(fail_b), .score(score_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic en, jl, jr;
        logic exp_gq, exp_busy;
    } vec_t;
    vec_t vecs [6];

    logic [34:0] rst_map_a, exp_map;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    // Issue one jump on DUT B and run its 3-tick scroll; returns with B in LAND.
    task automatic jump_b(input logic left, input logic [6:0] m, input logic [6:0] t);
        gmap = m; gtype = t; jl = left; jr = !left;
        #1 chk("B jump gen_req", {63'd0, gen_req_b}, 64'd1);
        cyc();
        jl = 1'b0; jr = 1'b0;
        run_ticks(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rst_map_a = '0;
        rst_map_a[3*7+3] = 1'b1;

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; tick = 1'b0; jl = 1'b0; jr = 1'b0;
        gmap = '0; gtype = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("A rst row_map", row_map_a, rst_map_a);
        chk("A rst row_type", row_type_a, 0);
        chk("A rst char_col", char_col_a, 3);
        chk("A rst scroll_cnt", scroll_cnt_a, 0);
        chk("A rst busy", busy_a, 0);
        chk("A rst jump_fail", fail_a, 0);
        chk("A rst score", score_a, 0);
        chk("A rst gen_req", gen_req_a, 0);
        chk("B rst row_map", row_map_b, 35'h8);

        // IDLE decode table; ticks held high so the accepting cycle's tick must not count
        gmap = 7'b0001000; gtype = '0; tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            en_a = vecs[i].en; jl = vecs[i].jl; jr = vecs[i].jr;
            #1 chk($sformatf("vec%0d gen_req", i), gen_req_a, vecs[i].exp_gq);
            cyc();
            jl = 1'b0; jr = 1'b0; en_a = 1'b0;
            chk($sformatf("vec%0d busy", i), busy_a, vecs[i].exp_busy);
        end
        tick = 1'b0;
        chk("A scroll start cnt", scroll_cnt_a, 0);

        // Mid-scroll jumps are ignored
        run_ticks(100);
        chk("A cnt 100", scroll_cnt_a, 100);
        en_a = 1'b1; jl = 1'b1;
        #1 chk("A scroll jump gen_req", gen_req_a, 0);
        cyc();
        jl = 1'b0; jr = 1'b1;
        cyc();
        jr = 1'b0;
        chk("A cnt after jumps", scroll_cnt_a, 100);
        run_ticks(99);
        chk("A cnt 199", scroll_cnt_a, 199);
        chk("A grid pre-shift", row_map_a, rst_map_a);
        run_ticks(1);
        exp_map = '0; exp_map[3] = 1'b1; exp_map[4*7+3] = 1'b1;
        chk("A shift char_col", char_col_a, 4);
        chk("A shift cnt", scroll_cnt_a, 0);
        chk("A shift row_map", row_map_a, exp_map);
        chk("A land busy", busy_a, 1);
        chk("A land no fail yet", fail_a, 0);
        cyc();
        chk("A empty land fail", fail_a, 1);
        chk("A empty land score", score_a, 0);

        // FAIL is frozen
        jr = 1'b1;
        #1 chk("A fail gen_req", gen_req_a, 0);
        cyc();
        jr = 1'b0;
        run_ticks(3);
        chk("A fail row_map", row_map_a, exp_map);
        chk("A fail char_col", char_col_a, 4);
        chk("A fail busy", busy_a, 1);

        // Reset exits FAIL; reset mid-scroll restores everything
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("A rst clears fail", fail_a, 0);
        gmap = 7'h7f; jr = 1'b1;
        #1 chk("A 2nd jump gen_req", gen_req_a, 1);
        cyc();
        jr = 1'b0;
        run_ticks(100);
        chk("A 2nd cnt 100", scroll_cnt_a, 100);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("A midrst cnt", scroll_cnt_a, 0);
        chk("A midrst busy", busy_a, 0);
        chk("A midrst char_col", char_col_a, 3);
        chk("A midrst row_map", row_map_a, rst_map_a);
        chk("A midrst gen_req", gen_req_a, 0);
        en_a = 1'b0;

        // DUT B: solid landing left
        en_b = 1'b1;
        jump_b(1'b1, 7'b0000100, 7'b0);
        chk("B land char_col", char_col_b, 2);
        chk("B land row_map", row_map_b, (35'h1 << 2) | (35'h1 << 10));
        chk("B land busy", busy_b, 1);
        cyc();
        chk("B idle busy", busy_b, 0);
        chk("B score 1", score_b, 1);
        chk("B no fail", fail_b, 0);

        // Four more landings: score saturates at 3
        jump_b(1'b1, 7'h7f, 7'b0); cyc();
        chk("B score 2", score_b, 2);
        jump_b(1'b1, 7'h7f, 7'b0); cyc();
        chk("B score 3", score_b, 3);
        jump_b(1'b0, 7'h7f, 7'b0); cyc();
        chk("B col 1", char_col_b, 1);
        jump_b(1'b1, 7'h7f, 7'b0); cyc();
        chk("B score sat", score_b, 3);
        chk("B col 0", char_col_b, 0);
        exp_map = {7'h04, 7'h7f, 7'h7f, 7'h7f, 7'h7f};
        chk("B grid after 5", row_map_b, exp_map);

        // Edge jump at column 0
        jl = 1'b1;
        #1 chk("B edge gen_req", gen_req_b, 0);
        cyc();
        jl = 1'b0;
        chk("B edge fail", fail_b, 1);
        jr = 1'b1;
        #1 chk("B edge frozen gen_req", gen_req_b, 0);
        cyc();
        jr = 1'b0;
        chk("B edge row_map", row_map_b, exp_map);
        chk("B edge char_col", char_col_b, 0);

        // Hazard landing
        rst = 1'b1; cyc(); rst = 1'b0;
        jump_b(1'b1, 7'b0000100, 7'b0000100);
        chk("B hazard row_type", row_type_b[6:0], 7'b0000100);
        cyc();
        chk("B hazard fail", fail_b, 1);
        chk("B hazard score", score_b, 0);
        chk("B hazard char_col", char_col_b, 2);
        jl = 1'b1;
        #1 chk("B hazard gen_req", gen_req_b, 0);
        cyc();
        jl = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
